// File: rtl/branch_issue_sched.sv
// branch_issue_sched: in-order issue queue for the branch unit.
// Entries wait in a circular buffer until both operands are valid.
// Operands become valid when a matching result appears on the CDB.
// Only the head entry can issue, and at most one entry issues per cycle.
// Optional feature (macro BRANCH_SCHED_BYPASS_EN): the head can issue in
// the same cycle that the CDB delivers its last missing operand. In that
// case the operand value is taken directly from the CDB.
// CDB packing, MSB to LSB: {valid, dest tag, flags, result}.
//
// Handshake: a branch op moves into the queue on a rising edge where
// enq_v_i && enq_ready_o. enq_ready_o depends only on the queue being full;
// it does not depend on an issue in the same cycle. An issue to the branch
// unit is a one-cycle pulse on exe_v_o, and the issue data is valid with it.
module branch_issue_sched #(
   parameter int DEPTH_P      = 4,
   parameter int WIDTH_OP     = 6,
   parameter int WORD_SIZE_P  = 16,
   parameter int ROB_ENTRY    = 16,
   parameter int NUM_PHYS_REG = 32,
   parameter int FLAGS_W      = 4,
   localparam int ROB_W       = $clog2(ROB_ENTRY),
   localparam int TAG_W       = $clog2(NUM_PHYS_REG),
   localparam int CDB_WIDTH   = 1 + TAG_W + FLAGS_W + WORD_SIZE_P,
   localparam int AW          = $clog2(DEPTH_P)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   enq_v_i,
   output logic                   enq_ready_o,
   input  logic [WIDTH_OP-1:0]    enq_opcode_i,
   input  logic [WORD_SIZE_P-1:0] enq_pc_i,
   input  logic [ROB_W-1:0]       enq_rob_dest_i,
   input  logic [TAG_W-1:0]       enq_reg_dest_i,
   input  logic                   enq_op1_v_i,
   input  logic [WORD_SIZE_P-1:0] enq_op1_i,
   input  logic [TAG_W-1:0]       enq_op1_tag_i,
   input  logic                   enq_op2_v_i,
   input  logic [WORD_SIZE_P-1:0] enq_op2_i,
   input  logic [TAG_W-1:0]       enq_op2_tag_i,
   input  logic [CDB_WIDTH-1:0]   cdb_i,
   input  logic                   flush_i,
   output logic                   exe_v_o,
   output logic [WIDTH_OP-1:0]    opcode_o,
   output logic [WORD_SIZE_P-1:0] pc_o,
   output logic [WORD_SIZE_P-1:0] operand1_o,
   output logic [WORD_SIZE_P-1:0] operand2_o,
   output logic [ROB_W-1:0]       rob_dest_o,
   output logic [TAG_W-1:0]       reg_dest_o,
   output logic [AW:0]            count_o
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   // Pointers carry one wrap bit above the index.
   logic [AW:0] r_head, r_tail;

   // Storage for each queue entry.
   logic [WIDTH_OP-1:0]    r_opc     [DEPTH_P];
   logic [WORD_SIZE_P-1:0] r_pc      [DEPTH_P];
   logic [ROB_W-1:0]       r_rob     [DEPTH_P];
   logic [TAG_W-1:0]       r_rdst    [DEPTH_P];
   logic [DEPTH_P-1:0]     r_op1_v;
   logic [DEPTH_P-1:0]     r_op2_v;
   logic [WORD_SIZE_P-1:0] r_op1     [DEPTH_P];
   logic [WORD_SIZE_P-1:0] r_op2     [DEPTH_P];
   logic [TAG_W-1:0]       r_op1_tag [DEPTH_P];
   logic [TAG_W-1:0]       r_op2_tag [DEPTH_P];

   logic [AW-1:0]          w_head_idx, w_tail_idx;
   logic                   w_full, w_empty, w_enq, w_pop;
   logic                   w_cdb_v;
   logic [TAG_W-1:0]       w_cdb_dest;
   logic [WORD_SIZE_P-1:0] w_cdb_res;
   logic                   w_unused_flags;
   logic [DEPTH_P-1:0]     w_wake1, w_wake2;
   logic                   w_enq_op1_v, w_enq_op2_v;
   logic [WORD_SIZE_P-1:0] w_enq_op1, w_enq_op2;
   logic                   w_h_op1_rdy, w_h_op2_rdy;
   logic [WORD_SIZE_P-1:0] w_h_op1, w_h_op2;

   assign w_cdb_v        = cdb_i[CDB_WIDTH-1];
   assign w_cdb_dest     = cdb_i[WORD_SIZE_P+FLAGS_W +: TAG_W];
   assign w_cdb_res      = cdb_i[WORD_SIZE_P-1:0];
   assign w_unused_flags = ^cdb_i[WORD_SIZE_P +: FLAGS_W];

   assign w_head_idx  = r_head[AW-1:0];
   assign w_tail_idx  = r_tail[AW-1:0];
   assign w_empty     = (r_head == r_tail);
   assign w_full      = (w_head_idx == w_tail_idx) && (r_head[AW] != r_tail[AW]);
   assign w_enq       = enq_v_i && !w_full;
   assign enq_ready_o = !w_full;
   assign count_o     = r_tail - r_head;

   // An enqueuing operand captures a same-cycle broadcast so the result is not lost.
   assign w_enq_op1_v = enq_op1_v_i || (w_cdb_v && (enq_op1_tag_i == w_cdb_dest));
   assign w_enq_op2_v = enq_op2_v_i || (w_cdb_v && (enq_op2_tag_i == w_cdb_dest));
   assign w_enq_op1   = enq_op1_v_i ? enq_op1_i : w_cdb_res;
   assign w_enq_op2   = enq_op2_v_i ? enq_op2_i : w_cdb_res;

   // Find stored operands that this cycle's broadcast wakes up.
   always_comb begin
      w_wake1 = '0;
      w_wake2 = '0;
      for (int i = 0; i < DEPTH_P; i++) begin
         w_wake1[i] = w_cdb_v && !r_op1_v[i] && (r_op1_tag[i] == w_cdb_dest);
         w_wake2[i] = w_cdb_v && !r_op2_v[i] && (r_op2_tag[i] == w_cdb_dest);
      end
   end

   // Decide if the head can issue, and which operand values it sends.
   always_comb begin
      w_h_op1_rdy = r_op1_v[w_head_idx];
      w_h_op2_rdy = r_op2_v[w_head_idx];
      w_h_op1     = r_op1[w_head_idx];
      w_h_op2     = r_op2[w_head_idx];
`ifdef BRANCH_SCHED_BYPASS_EN
      if (w_wake1[w_head_idx]) begin
         w_h_op1_rdy = 1'b1;
         w_h_op1     = w_cdb_res;
      end
      if (w_wake2[w_head_idx]) begin
         w_h_op2_rdy = 1'b1;
         w_h_op2     = w_cdb_res;
      end
`else
      // The head waits for the stored wakeup and issues one cycle later.
`endif
      w_pop = !w_empty && w_h_op1_rdy && w_h_op2_rdy;
   end

   // Update the head and tail pointers. Flush empties the queue.
   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_enq) r_tail <= r_tail + PTR_ONE;
         if (w_pop) r_head <= r_head + PTR_ONE;
      end
   end

   // Operand valid bits: set by wakeup, and loaded on enqueue (the tail slot is always free).
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_op1_v <= '0;
         r_op2_v <= '0;
      end else if (!flush_i) begin
         for (int i = 0; i < DEPTH_P; i++) begin
            if (w_wake1[i]) r_op1_v[i] <= 1'b1;
            if (w_wake2[i]) r_op2_v[i] <= 1'b1;
            if (w_enq && (w_tail_idx == AW'(i))) begin
               r_op1_v[i] <= w_enq_op1_v;
               r_op2_v[i] <= w_enq_op2_v;
            end
         end
      end
   end

   // Entry payload: write the fields on enqueue, and capture woken operand values.
   always_ff @(posedge clk_i) begin
      if (!reset_i && !flush_i) begin
         for (int i = 0; i < DEPTH_P; i++) begin
            if (w_wake1[i]) r_op1[i] <= w_cdb_res;
            if (w_wake2[i]) r_op2[i] <= w_cdb_res;
            if (w_enq && (w_tail_idx == AW'(i))) begin
               r_opc[i]     <= enq_opcode_i;
               r_pc[i]      <= enq_pc_i;
               r_rob[i]     <= enq_rob_dest_i;
               r_rdst[i]    <= enq_reg_dest_i;
               r_op1[i]     <= w_enq_op1;
               r_op2[i]     <= w_enq_op2;
               r_op1_tag[i] <= enq_op1_tag_i;
               r_op2_tag[i] <= enq_op2_tag_i;
            end
         end
      end
   end

   // Registered issue to the branch unit: a one-cycle pulse for each popped entry.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         exe_v_o    <= 1'b0;
         opcode_o   <= '0;
         pc_o       <= '0;
         operand1_o <= '0;
         operand2_o <= '0;
         rob_dest_o <= '0;
         reg_dest_o <= '0;
      end else if (flush_i) begin
         exe_v_o <= 1'b0;
      end else begin
         exe_v_o <= w_pop;
         if (w_pop) begin
            opcode_o   <= r_opc[w_head_idx];
            pc_o       <= r_pc[w_head_idx];
            operand1_o <= w_h_op1;
            operand2_o <= w_h_op2;
            rob_dest_o <= r_rob[w_head_idx];
            reg_dest_o <= r_rdst[w_head_idx];
         end
      end
   end

endmodule

// File: tb/tb_branch_issue_sched.sv
// tb_branch_issue_sched: directed self-checking bench for branch_issue_sched.
// Works with or without BRANCH_SCHED_BYPASS_EN.
module tb_branch_issue_sched;

   localparam int W     = 16;
   localparam int OPW   = 6;
   localparam int ROBW  = 4;
   localparam int TAGW  = 5;
   localparam int CDBW  = 1 + TAGW + 4 + W;
`ifdef BRANCH_SCHED_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset_i = 1'b1;
   logic            enq_v_i = 1'b0;
   logic            enq_ready_o;
   logic [OPW-1:0]  enq_opcode_i = '0;
   logic [W-1:0]    enq_pc_i = '0;
   logic [ROBW-1:0] enq_rob_dest_i = '0;
   logic [TAGW-1:0] enq_reg_dest_i = '0;
   logic            enq_op1_v_i = 1'b0;
   logic [W-1:0]    enq_op1_i = '0;
   logic [TAGW-1:0] enq_op1_tag_i = '0;
   logic            enq_op2_v_i = 1'b0;
   logic [W-1:0]    enq_op2_i = '0;
   logic [TAGW-1:0] enq_op2_tag_i = '0;
   logic [CDBW-1:0] cdb_i = '0;
   logic            flush_i = 1'b0;
   logic            exe_v_o;
   logic [OPW-1:0]  opcode_o;
   logic [W-1:0]    pc_o, operand1_o, operand2_o;
   logic [ROBW-1:0] rob_dest_o;
   logic [TAGW-1:0] reg_dest_o;
   logic [2:0]      count_o;

   branch_issue_sched #(
      .DEPTH_P(4), .WIDTH_OP(OPW), .WORD_SIZE_P(W), .ROB_ENTRY(16),
      .NUM_PHYS_REG(32), .FLAGS_W(4)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .enq_v_i(enq_v_i), .enq_ready_o(enq_ready_o),
      .enq_opcode_i(enq_opcode_i), .enq_pc_i(enq_pc_i),
      .enq_rob_dest_i(enq_rob_dest_i), .enq_reg_dest_i(enq_reg_dest_i),
      .enq_op1_v_i(enq_op1_v_i), .enq_op1_i(enq_op1_i), .enq_op1_tag_i(enq_op1_tag_i),
      .enq_op2_v_i(enq_op2_v_i), .enq_op2_i(enq_op2_i), .enq_op2_tag_i(enq_op2_tag_i),
      .cdb_i(cdb_i), .flush_i(flush_i),
      .exe_v_o(exe_v_o), .opcode_o(opcode_o), .pc_o(pc_o),
      .operand1_o(operand1_o), .operand2_o(operand2_o),
      .rob_dest_o(rob_dest_o), .reg_dest_o(reg_dest_o), .count_o(count_o)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int n_issued = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs apply at the next rising edge. Outputs are read 1 time unit after that edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      enq_v_i = 1'b0;
      cdb_i   = '0;
      flush_i = 1'b0;
   endtask

   task automatic offer(input logic [W-1:0] pc,
                        input logic v1, input logic [W-1:0] o1, input logic [TAGW-1:0] t1,
                        input logic v2, input logic [W-1:0] o2, input logic [TAGW-1:0] t2);
      enq_v_i       = 1'b1;
      enq_pc_i      = pc;
      enq_op1_v_i   = v1;
      enq_op1_i     = o1;
      enq_op1_tag_i = t1;
      enq_op2_v_i   = v2;
      enq_op2_i     = o2;
      enq_op2_tag_i = t2;
   endtask

   task automatic bcast(input logic [TAGW-1:0] dest, input logic [W-1:0] res);
      cdb_i = {1'b1, dest, 4'h0, res};
   endtask

   // Collect issued pcs and compare them with the expected program order.
   task automatic sample_issue();
      if (exe_v_o) begin
         n_issued++;
         if (exp_q.size() > 0) check("b2b_order", pc_o, exp_q.pop_front());
      end
      check("b2b_cnt_le4", count_o <= 3'd4, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Hold reset with an offer present. The offered op must not be accepted.
      offer(16'h00AB, 1, 16'h1, 0, 1, 16'h2, 0);
      step(); step();
      reset_i = 1'b0;
      idle();
      check("rst_count", count_o, 0);
      check("rst_ready", enq_ready_o, 1);
      check("rst_exe_v", exe_v_o, 0);
      check("rst_pc", pc_o, 0);

      // Single op with both operands valid: two-cycle latency.
      offer(16'h0010, 1, 16'hAAAA, 0, 1, 16'hBBBB, 0);
      enq_opcode_i = 6'd5; enq_rob_dest_i = 4'd3; enq_reg_dest_i = 5'd9;
      step();
      idle();
      check("bl_count1", count_o, 1);
      check("bl_exe_early", exe_v_o, 0);
      step();
      check("bl_exe_v", exe_v_o, 1);
      check("bl_pc", pc_o, 16'h0010);
      check("bl_op1", operand1_o, 16'hAAAA);
      check("bl_op2", operand2_o, 16'hBBBB);
      check("bl_opcode", opcode_o, 5);
      check("bl_rob", rob_dest_o, 3);
      check("bl_reg", reg_dest_o, 9);
      check("bl_count0", count_o, 0);
      step();
      check("bl_pulse", exe_v_o, 0);

      // Fill the queue. The head waits on tag 5.
      offer(16'h0020, 0, 16'h0, 5, 1, 16'h2, 0); step();
      for (int k = 1; k < 4; k++) begin
         offer(16'h0020 + W'(k), 1, 16'h1, 0, 1, 16'h2, 0);
         step();
      end
      check("full_count", count_o, 4);
      check("full_ready", enq_ready_o, 0);
      check("full_exe_v", exe_v_o, 0);
      offer(16'h0099, 1, 16'h1, 0, 1, 16'h2, 0);
      step();
      idle();
      check("full_reject", count_o, 4);
      bcast(5, 16'h1234);
      step();
      idle();
      check("wake_exe_v_first", exe_v_o, BYP);
      if (!BYP) step();
      check("wake_exe_v", exe_v_o, 1);
      check("wake_pc", pc_o, 16'h0020);
      check("wake_op1", operand1_o, 16'h1234);
      check("wake_count", count_o, 3);
      for (int k = 1; k < 4; k++) begin
         step();
         check("drain_exe_v", exe_v_o, 1);
         check("drain_pc", pc_o, 16'h0020 + W'(k));
      end
      step();
      check("drain_done_exe", exe_v_o, 0);
      check("drain_done_cnt", count_o, 0);

      // The head is blocked on tag 7. The second entry is ready but must wait behind it.
      offer(16'h0030, 0, 16'h0, 7, 1, 16'h3, 0); step();
      offer(16'h0031, 1, 16'h5, 0, 1, 16'h6, 0); step();
      idle();
      for (int k = 0; k < 3; k++) begin
         check("order_blocked", exe_v_o, 0);
         step();
      end
      bcast(7, 16'h0777);
      step();
      idle();
      check("order_exe_first", exe_v_o, BYP);
      if (!BYP) step();
      check("order_head_v", exe_v_o, 1);
      check("order_head_pc", pc_o, 16'h0030);
      check("order_head_op1", operand1_o, 16'h0777);
      step();
      check("order_sec_v", exe_v_o, 1);
      check("order_sec_pc", pc_o, 16'h0031);
      check("order_sec_op1", operand1_o, 16'h0005);
      step();
      check("order_idle", exe_v_o, 0);

      // Broadcast in the same cycle as enqueue: operand2 is captured from the CDB.
      offer(16'h0040, 1, 16'h0011, 0, 0, 16'h0, 3);
      bcast(3, 16'h00FF);
      step();
      idle();
      check("enqwake_count", count_o, 1);
      step();
      check("enqwake_exe_v", exe_v_o, 1);
      check("enqwake_pc", pc_o, 16'h0040);
      check("enqwake_op1", operand1_o, 16'h0011);
      check("enqwake_op2", operand2_o, 16'h00FF);
      step();

      // Flush with three blocked entries and a same-cycle offer.
      for (int k = 0; k < 3; k++) begin
         offer(16'h0050 + W'(k), 0, 16'h0, 9, 1, 16'h1, 0);
         step();
      end
      check("fl_count3", count_o, 3);
      offer(16'h005F, 1, 16'h1, 0, 1, 16'h1, 0);
      flush_i = 1'b1;
      step();
      idle();
      check("fl_count0", count_o, 0);
      check("fl_exe_v", exe_v_o, 0);
      check("fl_ready", enq_ready_o, 1);
      bcast(9, 16'hAAAA);
      step();
      idle();
      for (int k = 0; k < 3; k++) begin
         check("fl_no_issue", exe_v_o, 0);
         step();
      end
      check("fl_still_empty", count_o, 0);

      // Flush on the edge where a ready head would otherwise issue.
      offer(16'h0060, 1, 16'h1, 0, 1, 16'h1, 0);
      step();
      idle();
      flush_i = 1'b1;
      step();
      idle();
      check("fl_issue_cut", exe_v_o, 0);
      check("fl_issue_cnt", count_o, 0);

      // Reset while the queue is full, with flush, offer and wakeup active in the same cycle.
      for (int k = 0; k < 4; k++) begin
         offer(16'h0070 + W'(k), 0, 16'h0, 11, 1, 16'h1, 0);
         step();
      end
      check("rst2_full", count_o, 4);
      offer(16'h007F, 1, 16'h1, 0, 1, 16'h1, 0);
      bcast(11, 16'hBEEF);
      flush_i = 1'b1;
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      idle();
      check("rst2_count", count_o, 0);
      check("rst2_ready", enq_ready_o, 1);
      check("rst2_exe_v", exe_v_o, 0);
      check("rst2_pc", pc_o, 0);
      check("rst2_op2", operand2_o, 0);
      bcast(11, 16'hBEEF);
      step();
      idle();
      step();
      check("rst2_no_issue", exe_v_o, 0);

      // Ten back-to-back enqueues. The pointers wrap around the queue.
      for (int k = 0; k < 10; k++) begin
         offer(16'h0100 + W'(k), 1, W'(k), 0, 1, 16'h0, 0);
         exp_q.push_back(16'h0100 + W'(k));
         step();
         sample_issue();
      end
      idle();
      for (int k = 0; k < 4; k++) begin
         step();
         sample_issue();
      end
      check("b2b_issued", n_issued, 10);
      check("b2b_q_empty", exp_q.size(), 0);
      check("b2b_count", count_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Safety limit on total simulation time.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
